// File: rtl/axilite_pkg.sv
// axilite_pkg
// Shared definitions for the AXI-Lite to local-bus bridge:
//   RESP_OKAY / RESP_SLVERR : AXI-Lite response codes driven on BRESP/RRESP
//   wr_state_t / rd_state_t : state encodings of the write and read FSMs
package axilite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_EXEC, R_RESP} rd_state_t;

endpackage

// File: rtl/axilite2lb_if.sv
// axilite2lb_if
// AXI-Lite channel bundle (AW, W, B, AR, R).
//   master modport : drives addresses, data, valids and bready/rready
//   slave modport  : drives the readys, responses and read data
// The *prot fields are carried for completeness; the bridge ignores them.
interface axilite2lb_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
);

  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;

  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;

  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;

  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/lb_timer.sv
// lb_timer
// Per-transaction local-bus timeout counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (held while the owning FSM is outside EXEC)
//   en         : count one EXEC cycle
//   expired    : high during the EXEC cycle whose count brings the counter to
//                all-ones, i.e. the (2**TMO_W-1)-th cycle spent waiting
module lb_timer #(
  parameter int TMO_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TMO_W-1:0] ALL_ONES = '1;
  localparam logic [TMO_W-1:0] ONE      = TMO_W'(1);
  localparam logic [TMO_W-1:0] LAST     = ALL_ONES - ONE;

  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != ALL_ONES)) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds completed EXEC cycles; this cycle completes the last one.
  assign expired = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/axilite2lb.sv
// axilite2lb
// AXI-Lite slave to simple local-bus bridge with independent write and read
// paths, one outstanding transaction per path, and a per-transaction timeout
// that turns a silent local bus into an SLVERR response.
//   clk, rst_n        : clock, asynchronous active-low reset
//   axil (slave)      : AXI-Lite AW/W/B/AR/R channels
//   lb_waddr/wdata/wstrb, lb_wen, lb_wready : local-bus write request/accept
//   lb_raddr, lb_ren, lb_rdata, lb_rvalid   : local-bus read request/response
// Every output is driven straight from a register.
module axilite2lb #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8,
  parameter int TMO_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  axilite2lb_if.slave       axil,
  output logic [ADDR_W-1:0] lb_waddr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic [STRB_W-1:0] lb_wstrb,
  output logic              lb_wen,
  input  logic              lb_wready,
  output logic [ADDR_W-1:0] lb_raddr,
  output logic              lb_ren,
  input  logic [DATA_W-1:0] lb_rdata,
  input  logic              lb_rvalid
);

  import axilite_pkg::*;

  // ---------------- write path ----------------
  wr_state_t         wr_state_q, wr_state_d;
  logic              awready_q, awready_d, wready_q, wready_d;
  logic              aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [ADDR_W-1:0] lb_waddr_q, lb_waddr_d;
  logic [DATA_W-1:0] lb_wdata_q, lb_wdata_d;
  logic [STRB_W-1:0] lb_wstrb_q, lb_wstrb_d;
  logic              lb_wen_q, lb_wen_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              aw_hs, w_hs, w_expired;

  lb_timer #(.TMO_W(TMO_W)) u_wr_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wr_state_q != W_EXEC),
    .en      (wr_state_q == W_EXEC),
    .expired (w_expired)
  );

  always_comb begin
    wr_state_d = wr_state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    lb_waddr_d = lb_waddr_q;
    lb_wdata_d = lb_wdata_q;
    lb_wstrb_d = lb_wstrb_q;
    lb_wen_d   = lb_wen_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    aw_hs      = awready_q && axil.awvalid;
    w_hs       = wready_q && axil.wvalid;
    unique case (wr_state_q)
      W_IDLE: begin
        // Each ready stays up until its own channel has been captured; AW and
        // W may land in any order, so the two captures are tracked separately.
        awready_d = !(aw_got_q || aw_hs);
        wready_d  = !(w_got_q || w_hs);
        if (aw_hs) begin
          lb_waddr_d = axil.awaddr;
          aw_got_d   = 1'b1;
        end
        if (w_hs) begin
          lb_wdata_d = axil.wdata;
          lb_wstrb_d = axil.wstrb;
          w_got_d    = 1'b1;
        end
        if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
          wr_state_d = W_EXEC;
          lb_wen_d   = 1'b1;
          aw_got_d   = 1'b0;
          w_got_d    = 1'b0;
        end
      end
      W_EXEC: begin
        // A real accept beats a simultaneous expiry.
        if (lb_wready || w_expired) begin
          wr_state_d = W_RESP;
          lb_wen_d   = 1'b0;
          bvalid_d   = 1'b1;
          bresp_d    = lb_wready ? RESP_OKAY : RESP_SLVERR;
        end
      end
      W_RESP: begin
        if (axil.bready) begin
          wr_state_d = W_IDLE;
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      lb_waddr_q <= '0;
      lb_wdata_q <= '0;
      lb_wstrb_q <= '0;
      lb_wen_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      lb_waddr_q <= lb_waddr_d;
      lb_wdata_q <= lb_wdata_d;
      lb_wstrb_q <= lb_wstrb_d;
      lb_wen_q   <= lb_wen_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
    end
  end

  // ---------------- read path ----------------
  rd_state_t         rd_state_q, rd_state_d;
  logic              arready_q, arready_d;
  logic [ADDR_W-1:0] lb_raddr_q, lb_raddr_d;
  logic              lb_ren_q, lb_ren_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              r_expired;

  lb_timer #(.TMO_W(TMO_W)) u_rd_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (rd_state_q != R_EXEC),
    .en      (rd_state_q == R_EXEC),
    .expired (r_expired)
  );

  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    lb_raddr_d = lb_raddr_q;
    lb_ren_d   = lb_ren_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    unique case (rd_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (arready_q && axil.arvalid) begin
          rd_state_d = R_EXEC;
          arready_d  = 1'b0;
          lb_raddr_d = axil.araddr;
          lb_ren_d   = 1'b1;
        end
      end
      R_EXEC: begin
        if (lb_rvalid || r_expired) begin
          rd_state_d = R_RESP;
          lb_ren_d   = 1'b0;
          rvalid_d   = 1'b1;
          rdata_d    = lb_rvalid ? lb_rdata : '0;
          rresp_d    = lb_rvalid ? RESP_OKAY : RESP_SLVERR;
        end
      end
      R_RESP: begin
        if (axil.rready) begin
          rd_state_d = R_IDLE;
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      lb_raddr_q <= '0;
      lb_ren_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      lb_raddr_q <= lb_raddr_d;
      lb_ren_q   <= lb_ren_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  // ---------------- outputs ----------------
  assign axil.awready = awready_q;
  assign axil.wready  = wready_q;
  assign axil.bvalid  = bvalid_q;
  assign axil.bresp   = bresp_q;
  assign axil.arready = arready_q;
  assign axil.rvalid  = rvalid_q;
  assign axil.rdata   = rdata_q;
  assign axil.rresp   = rresp_q;
  assign lb_waddr     = lb_waddr_q;
  assign lb_wdata     = lb_wdata_q;
  assign lb_wstrb     = lb_wstrb_q;
  assign lb_wen       = lb_wen_q;
  assign lb_raddr     = lb_raddr_q;
  assign lb_ren       = lb_ren_q;

endmodule

// File: tb/tb_axilite2lb.sv
// tb_axilite2lb
// Scoreboard bench for axilite2lb: stimulus tasks push expected local-bus
// requests and AXI responses into queues; independent monitors pop and
// compare whenever the DUT presents a local-bus request or a B/R response.
module tb_axilite2lb;
  import axilite_pkg::*;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int TMO_W  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axilite2lb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axil ();

  logic [ADDR_W-1:0] lb_waddr, lb_raddr;
  logic [DATA_W-1:0] lb_wdata;
  logic [DATA_W-1:0] lb_rdata = '0;
  logic [STRB_W-1:0] lb_wstrb;
  logic              lb_wen, lb_ren;
  logic              lb_wready = 1'b0;
  logic              lb_rvalid = 1'b0;

  axilite2lb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W), .TMO_W(TMO_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .axil      (axil),
    .lb_waddr  (lb_waddr),
    .lb_wdata  (lb_wdata),
    .lb_wstrb  (lb_wstrb),
    .lb_wen    (lb_wen),
    .lb_wready (lb_wready),
    .lb_raddr  (lb_raddr),
    .lb_ren    (lb_ren),
    .lb_rdata  (lb_rdata),
    .lb_rvalid (lb_rvalid)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } lbw_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
  } rsp_t;

  lbw_t              exp_lbw[$];
  logic [ADDR_W-1:0] exp_lbr[$];
  logic [1:0]        exp_b[$];
  rsp_t              exp_r[$];

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // local-bus model configuration (-1 = never respond) and statistics
  int                wr_delay = 0;
  int                rd_delay = 0;
  logic [DATA_W-1:0] rd_value = '0;
  int wcnt = 0, rcnt = 0;
  int wen_cycles = 0, wen_pulses = 0, ren_cycles = 0;
  bit both_seen = 1'b0;
  int hs_cyc = 0, b_cyc = 0;

  lbw_t              mon_w;
  logic [ADDR_W-1:0] mon_ra;
  logic [1:0]        mon_b;
  rsp_t              mon_r;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Local-bus slave model: answers after a programmable number of cycles
  // and checks each new request against the scoreboard.
  always @(negedge clk) begin
    if (lb_wen && lb_ren) both_seen = 1'b1;
    if (lb_wen) begin
      if (wcnt == 0) begin
        wen_pulses++;
        if (exp_lbw.size() == 0) chk("lbw_unexpected", 1, 0);
        else begin
          mon_w = exp_lbw.pop_front();
          chk("lb_waddr", lb_waddr, mon_w.addr);
          chk("lb_wdata", lb_wdata, mon_w.data);
          chk("lb_wstrb", lb_wstrb, mon_w.strb);
        end
      end
      wen_cycles++;
      lb_wready = (wcnt == wr_delay);
      wcnt++;
    end else begin
      lb_wready = 1'b0;
      wcnt = 0;
    end
    if (lb_ren) begin
      if (rcnt == 0) begin
        if (exp_lbr.size() == 0) chk("lbr_unexpected", 1, 0);
        else begin
          mon_ra = exp_lbr.pop_front();
          chk("lb_raddr", lb_raddr, mon_ra);
        end
      end
      ren_cycles++;
      lb_rvalid = (rcnt == rd_delay);
      lb_rdata  = rd_value;
      rcnt++;
    end else begin
      lb_rvalid = 1'b0;
      rcnt = 0;
    end
  end

  // B and R response monitors (bready/rready are held high, so each
  // response is visible for exactly one negedge).
  always @(negedge clk) begin
    if (rst_n && axil.bvalid && axil.bready) begin
      b_cyc = cyc;
      $display("[%0t] B   bresp=%0b", $time, axil.bresp);
      if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
      else begin
        mon_b = exp_b.pop_front();
        chk("bresp", axil.bresp, mon_b);
      end
    end
    if (rst_n && axil.rvalid && axil.rready) begin
      $display("[%0t] R   rdata=0x%08h rresp=%0b", $time, axil.rdata, axil.rresp);
      if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
      else begin
        mon_r = exp_r.pop_front();
        chk("rdata", axil.rdata, mon_r.data);
        chk("rresp", axil.rresp, mon_r.resp);
      end
    end
  end

  task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                              input logic [STRB_W-1:0] s, input logic [1:0] resp);
    lbw_t e;
    e.addr = a; e.data = d; e.strb = s;
    exp_lbw.push_back(e);
    exp_b.push_back(resp);
  endtask

  task automatic expect_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             input logic [1:0] resp);
    rsp_t e;
    e.data = d; e.resp = resp;
    exp_lbr.push_back(a);
    exp_r.push_back(e);
  endtask

  // AW and W presented from relative cycles aw_dly / w_dly; returns just
  // after the edge on which the later of the two handshakes happened.
  task automatic axi_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input logic [STRB_W-1:0] s, input int aw_dly, input int w_dly);
    int c = 0;
    bit aw_done = 1'b0, w_done = 1'b0, aw_hs, w_hs;
    axil.awaddr = a;
    axil.wdata  = d;
    axil.wstrb  = s;
    while (!(aw_done && w_done) && c < 200) begin
      axil.awvalid = !aw_done && (c >= aw_dly);
      axil.wvalid  = !w_done && (c >= w_dly);
      @(negedge clk);
      aw_hs = axil.awvalid && axil.awready;
      w_hs  = axil.wvalid && axil.wready;
      @(posedge clk); #1;
      aw_done = aw_done | aw_hs;
      w_done  = w_done | w_hs;
      c++;
    end
    axil.awvalid = 1'b0;
    axil.wvalid  = 1'b0;
    if (!(aw_done && w_done)) chk("aw_w_handshake_timeout", 0, 1);
  endtask

  task automatic axi_read(input logic [ADDR_W-1:0] a);
    int c = 0;
    bit hs = 1'b0;
    axil.araddr  = a;
    axil.arvalid = 1'b1;
    while (!hs && c < 200) begin
      @(negedge clk);
      hs = axil.arready;
      @(posedge clk); #1;
      c++;
    end
    axil.arvalid = 1'b0;
    if (!hs) chk("ar_handshake_timeout", 0, 1);
  endtask

  task automatic wait_b();
    int g = 0;
    while (exp_b.size() != 0 && g < 1000) begin
      @(posedge clk); #1;
      g++;
    end
    if (exp_b.size() != 0) begin
      chk("b_wait_timeout", 0, 1);
      exp_b.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_r();
    int g = 0;
    while (exp_r.size() != 0 && g < 1000) begin
      @(posedge clk); #1;
      g++;
    end
    if (exp_r.size() != 0) begin
      chk("r_wait_timeout", 0, 1);
      exp_r.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    axil.awaddr = '0; axil.awprot = '0; axil.awvalid = 1'b0;
    axil.wdata = '0;  axil.wstrb = '0;  axil.wvalid = 1'b0;
    axil.araddr = '0; axil.arprot = '0; axil.arvalid = 1'b0;
    axil.bready = 1'b1;
    axil.rready = 1'b1;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", axil.awready, 0);
    chk("rst_wready",  axil.wready,  0);
    chk("rst_arready", axil.arready, 0);
    chk("rst_bvalid",  axil.bvalid,  0);
    chk("rst_rvalid",  axil.rvalid,  0);
    chk("rst_lb_wen",  lb_wen,       0);
    chk("rst_lb_ren",  lb_ren,       0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("awready_after_rst", axil.awready, 1);
    chk("wready_after_rst",  axil.wready,  1);
    chk("arready_after_rst", axil.arready, 1);

    // ---- 1: basic write, immediate accept ----
    wr_delay = 0; wen_cycles = 0;
    expect_write(16'h0010, 32'hDEADBEEF, 4'hF, RESP_OKAY);
    axi_write(16'h0010, 32'hDEADBEEF, 4'hF, 0, 0);
    hs_cyc = cyc;
    wait_b();
    chk("t1_wen_cycles", wen_cycles, 1);
    // handshake edge N, lb_wen during the cycle after N, bvalid after edge N+1
    chk("t1_b_latency_edges", b_cyc - hs_cyc, 1);

    // ---- 2: read with 3-cycle local-bus delay ----
    rd_delay = 3; rd_value = 32'hDEADBEEF; ren_cycles = 0;
    expect_read(16'h0010, 32'hDEADBEEF, RESP_OKAY);
    axi_read(16'h0010);
    wait_r();
    chk("t2_ren_cycles", ren_cycles, 4);

    // ---- 3: W five cycles before AW, partial strobe ----
    wr_delay = 1; wen_cycles = 0; wen_pulses = 0;
    expect_write(16'h0020, 32'h12345678, 4'h3, RESP_OKAY);
    axi_write(16'h0020, 32'h12345678, 4'h3, 5, 0);
    wait_b();
    chk("t3_wen_pulses", wen_pulses, 1);
    chk("t3_wen_cycles", wen_cycles, 2);

    // ---- 4: read timeout, then a normal read ----
    rd_delay = -1; rd_value = 32'hCAFEF00D; ren_cycles = 0;
    expect_read(16'h0030, 32'h0, RESP_SLVERR);
    axi_read(16'h0030);
    wait_r();
    chk("t4_ren_cycles", ren_cycles, 15);
    rd_delay = 1; rd_value = 32'h01020304;
    expect_read(16'h0034, 32'h01020304, RESP_OKAY);
    axi_read(16'h0034);
    wait_r();

    // ---- 4b: write timeout ----
    wr_delay = -1; wen_cycles = 0;
    expect_write(16'h0038, 32'h0BADF00D, 4'hC, RESP_SLVERR);
    axi_write(16'h0038, 32'h0BADF00D, 4'hC, 0, 0);
    wait_b();
    chk("t4b_wen_cycles", wen_cycles, 15);

    // ---- 5: concurrent write and read ----
    wr_delay = 2; rd_delay = 2; rd_value = 32'h55AA00FF; both_seen = 1'b0;
    expect_write(16'h0040, 32'hA5A55A5A, 4'hF, RESP_OKAY);
    expect_read(16'h0044, 32'h55AA00FF, RESP_OKAY);
    fork
      axi_write(16'h0040, 32'hA5A55A5A, 4'hF, 0, 0);
      axi_read(16'h0044);
    join
    wait_b();
    wait_r();
    chk("t5_wen_ren_overlap", both_seen, 1);

    // ---- 6: reset while the read is in EXEC ----
    rd_delay = -1;
    exp_lbr.push_back(16'h0050);   // request is issued, but no response will follow
    axi_read(16'h0050);
    repeat (3) @(posedge clk);
    #3;
    chk("t6_ren_before_rst", lb_ren, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_ren_async_rst",     lb_ren,       0);
    chk("t6_rvalid_async_rst",  axil.rvalid,  0);
    chk("t6_arready_async_rst", axil.arready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t6_arready_before_edge", axil.arready, 0);
    @(posedge clk); #1;
    chk("t6_arready_after_edge", axil.arready, 1);
    rd_delay = 0; rd_value = 32'h87654321;
    expect_read(16'h0060, 32'h87654321, RESP_OKAY);
    axi_read(16'h0060);
    wait_r();

    repeat (3) @(posedge clk);
    chk("scoreboard_leftover",
        exp_b.size() + exp_r.size() + exp_lbw.size() + exp_lbr.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
